// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchroniser plus a stability-count debouncer that
// produces a clean pressed level and one-cycle press/release pulses.
//
// state        | meaning
// IDLE         | debounced released, synchronised input agrees
// PRESS_WAIT   | synchronised input pressed, counting towards acceptance
// PRESSED      | debounced pressed, synchronised input agrees
// RELEASE_WAIT | synchronised input released, counting towards acceptance
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic button_db,
    output logic press_pulse,
    output logic release_pulse,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync2_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             busy_q, busy_d;
    logic             s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= button_raw ^ ACTIVE_LOW;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;

    // Outputs are computed from the next state so they are registered alongside it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        db_d      = db_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    db_d    = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d   = PRESSED;
                    cnt_d     = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    db_d      = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                db_d    = 1'b0;
            end
        endcase
        busy_d = (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            db_q      <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            press_q   <= press_d;
            release_q <= release_d;
            busy_q    <= busy_d;
        end
    end

    assign button_db     = db_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign busy          = busy_q;

endmodule
